avalon_input_capture: RTL

//  Avalon-MM slave that returns board inputs (KEY[3:1], SW[9:0]) to the HPS, the

---
 rtl/avalon_input_capture.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/avalon_input_capture.sv
// Purpose : Avalon-MM slave returning debounced KEY/SW board inputs, sticky edge events, IRQ and key-press count.
// Latency : readdata registered, fixed read latency 1 (no waitrequest); writes take effect on the write cycle.
// Backpr. : none - the slave always accepts; inputs are sampled every cycle, events are never dropped.
//
// Ports:
//   CLOCK_50       system clock, all logic on the rising edge
//   reset_n        synchronous active-low reset
//   key_n          raw push buttons, active-low, asynchronous
//   sw             raw slide switches, asynchronous
//   avs_address    register word address: 0 DATA, 1 MASK, 2 EDGE (W1C), 3 COUNT
//   avs_read       read strobe, data returned on avs_readdata the following cycle
//   avs_write      write strobe
//   avs_writedata  write data
//   avs_readdata   registered read data, holds its value between reads
//   irq            level interrupt, registered |(EDGE & MASK)

module avalon_input_capture #(
    parameter int N_KEYS          = 3,
    parameter int N_SW            = 10,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic                CLOCK_50,
    input  logic                reset_n,
    input  logic [N_KEYS-1:0]   key_n,
    input  logic [N_SW-1:0]     sw,
    input  logic [1:0]          avs_address,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    output logic [31:0]         avs_readdata,
    output logic                irq
);

    // Input vector layout shared by DATA, MASK and EDGE: {sw, keys}.
    localparam int W = N_SW + N_KEYS;

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_MASK  = 2'd1;
    localparam logic [1:0] ADDR_EDGE  = 2'd2;
    localparam logic [1:0] ADDR_COUNT = 2'd3;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    // One extra bit so the settle count DEBOUNCE_CYCLES+1 always fits.
    localparam int               ARM_W    = CNT_W + 1;
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(DEBOUNCE_CYCLES + 1);

    // Synchroniser flops reset to the idle pin levels (keys released, switches low)
    // so the first cycles after reset do not look like activity.
    localparam logic [W-1:0] SYNC_IDLE = {{N_SW{1'b0}}, {N_KEYS{1'b1}}};

    // ------------------------------------------------------------------
    // Two-flop synchroniser, keys inverted afterwards so 1 = pressed.
    // ------------------------------------------------------------------
    logic [W-1:0] sync_q1;
    logic [W-1:0] sync_q2;
    logic [W-1:0] sync_v;

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            sync_q1 <= SYNC_IDLE;
            sync_q2 <= SYNC_IDLE;
        end else begin
            sync_q1 <= {sw, key_n};
            sync_q2 <= sync_q1;
        end
    end

    assign sync_v = {sync_q2[W-1:N_KEYS], ~sync_q2[N_KEYS-1:0]};

    // ------------------------------------------------------------------
    // Per-bit debounce: the synced value must disagree with the accepted
    // value for DEBOUNCE_CYCLES consecutive cycles before it is taken.
    // Any cycle of agreement restarts the count, so short glitches vanish.
    // ------------------------------------------------------------------
    logic [W-1:0][CNT_W-1:0] db_cnt;
    logic [W-1:0]            db_q;
    logic [W-1:0]            db_nxt;

    always_comb begin
        db_nxt = db_q;
        for (int i = 0; i < W; i++) begin
            if ((sync_v[i] != db_q[i]) && (db_cnt[i] == DB_LAST)) begin
                db_nxt[i] = sync_v[i];
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            db_q   <= '0;
            db_cnt <= '0;
        end else begin
            db_q <= db_nxt;
            for (int i = 0; i < W; i++) begin
                if ((sync_v[i] == db_q[i]) || (db_cnt[i] == DB_LAST)) begin
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Arming: the debounced state needs up to DEBOUNCE_CYCLES+2 cycles to
    // catch up with the pins after reset. Until then changes are the
    // settle, not user activity, and must not raise events.
    // ------------------------------------------------------------------
    logic [ARM_W-1:0] arm_cnt;
    logic             armed;

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            arm_cnt <= '0;
            armed   <= 1'b0;
        end else if (!armed) begin
            if (arm_cnt == ARM_LAST) begin
                armed <= 1'b1;
            end else begin
                arm_cnt <= arm_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event detection on the debounced vector. Events are taken from the
    // next-state value so EDGE, COUNT and DATA all move on the same edge.
    // ------------------------------------------------------------------
    logic [N_KEYS-1:0] key_press;
    logic [N_SW-1:0]   sw_change;
    logic [W-1:0]      events;
    logic [15:0]       press_inc;

    assign key_press = armed ? (db_nxt[N_KEYS-1:0] & ~db_q[N_KEYS-1:0]) : '0;
    assign sw_change = armed ? (db_nxt[W-1:N_KEYS] ^ db_q[W-1:N_KEYS])  : '0;
    assign events    = {sw_change, key_press};

    // Several keys can be accepted on the same cycle; each counts once.
    always_comb begin
        press_inc = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            press_inc = press_inc + 16'(key_press[i]);
        end
    end

    // ------------------------------------------------------------------
    // Register file.
    // ------------------------------------------------------------------
    logic [W-1:0] mask_q;
    logic [W-1:0] edge_q;
    logic [15:0]  press_count;

    logic [W-1:0] mask_nxt;
    logic [W-1:0] edge_nxt;
    logic [15:0]  count_nxt;
    logic [W-1:0] edge_clr;
    logic         wr_mask;
    logic         wr_edge;
    logic         wr_count;

    assign wr_mask  = avs_write && (avs_address == ADDR_MASK);
    assign wr_edge  = avs_write && (avs_address == ADDR_EDGE);
    assign wr_count = avs_write && (avs_address == ADDR_COUNT);

    assign edge_clr  = wr_edge ? avs_writedata[W-1:0] : '0;
    assign mask_nxt  = wr_mask ? avs_writedata[W-1:0] : mask_q;
    // New events are OR-ed in after the clear, so a set beats a same-cycle W1C.
    assign edge_nxt  = (edge_q & ~edge_clr) | events;
    // Clear first, then add this cycle's presses; 16-bit add wraps naturally.
    assign count_nxt = (wr_count ? 16'h0000 : press_count) + press_inc;

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            mask_q      <= '0;
            edge_q      <= '0;
            press_count <= '0;
            irq         <= 1'b0;
        end else begin
            mask_q      <= mask_nxt;
            edge_q      <= edge_nxt;
            press_count <= count_nxt;
            // Built from next-state values so irq tracks EDGE with no extra lag.
            irq         <= |(edge_nxt & mask_nxt);
        end
    end

    // ------------------------------------------------------------------
    // Read path: mux of current (pre-write) register values, registered.
    // ------------------------------------------------------------------
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_DATA:  rd_mux = 32'(db_q);
            ADDR_MASK:  rd_mux = 32'(mask_q);
            ADDR_EDGE:  rd_mux = 32'(edge_q);
            ADDR_COUNT: rd_mux = {16'h0000, press_count};
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= rd_mux;
        end
    end

    // Upper write-data bits have no register behind them.
    logic unused_wdata;
    assign unused_wdata = ^avs_writedata[31:W];

endmodule
